corr_frame_seq: RTL and testbench

Frame sequencer for the direct-correspondence path. It generates raster read timing for two frame stores: frame1 (reference frame, feeding the line buffer) and frame0 (current frame, feeding the correspondence calculator). Frame0 streaming starts `LEAD_LINES` lines after frame1, so the line buffer already holds the rows that projection can hit. It also produces the frame_start/frame_end pulses that bracket the frame0 stream, and sits between the frame stores and the DirectCorrCalc/LineBufCtrl pair.

---
 rtl/corr_frame_seq_pkg.sv | 22 ++
 rtl/corr_frame_seq_if.sv | 30 +++
 rtl/corr_frame_seq_raster_cnt.sv | 81 ++++++++
 rtl/corr_frame_seq.sv | 98 +++++++++
 tb/tb_corr_frame_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/corr_frame_seq_pkg.sv
// Shared configuration for the RGB-D VO correspondence path: raster defaults,
// sequencer state encoding and a counter-width helper.
package RgbdVoConfigPk;

    localparam int CFG_H_ACT      = 640;
    localparam int CFG_H_BLANK    = 64;
    localparam int CFG_V_ACT      = 480;
    localparam int CFG_LEAD_LINES = 31;
    localparam int CFG_ADDR_BW    = 19;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LEAD  = 2'd1,
        SEQ_BOTH  = 2'd2,
        SEQ_DRAIN = 2'd3
    } seq_state_e;

    function automatic int cnt_bw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/corr_frame_seq_if.sv
// Control and frame-store read bundle of the correspondence frame sequencer.
interface corr_frame_seq_if
    import RgbdVoConfigPk::*;
#(
    parameter int ADDR_BW = CFG_ADDR_BW
);
    logic               i_start;
    logic               i_abort;
    logic               o_busy;
    logic               o_rd_en1;
    logic [ADDR_BW-1:0] o_rd_addr1;
    logic               o_rd_en0;
    logic [ADDR_BW-1:0] o_rd_addr0;
    logic               o_valid1;
    logic               o_valid0;
    logic               o_frame_start;
    logic               o_frame_end;

    modport slave (
        input  i_start, i_abort,
        output o_busy, o_rd_en1, o_rd_addr1, o_rd_en0, o_rd_addr0,
               o_valid1, o_valid0, o_frame_start, o_frame_end
    );

    modport master (
        output i_start, i_abort,
        input  o_busy, o_rd_en1, o_rd_addr1, o_rd_en0, o_rd_addr0,
               o_valid1, o_valid0, o_frame_start, o_frame_end
    );
endinterface

// File: rtl/corr_frame_seq_raster_cnt.sv
// One raster stream: x/y position, running read address and a registered
// read enable computed from the next position.
module raster_cnt
    import RgbdVoConfigPk::*;
#(
    parameter int H_ACT   = CFG_H_ACT,
    parameter int H_BLANK = CFG_H_BLANK,
    parameter int V_ACT   = CFG_V_ACT,
    parameter int ADDR_BW = CFG_ADDR_BW,
    parameter int Y_BW    = cnt_bw(V_ACT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic               i_act_nxt,
    output logic               o_eol,
    output logic [Y_BW-1:0]    o_y,
    output logic               o_rd_en,
    output logic [ADDR_BW-1:0] o_addr
);
    localparam int H_TOTAL = H_ACT + H_BLANK;
    localparam int X_BW    = cnt_bw(H_TOTAL);

    localparam logic [X_BW-1:0]    X_LAST    = X_BW'(H_TOTAL - 1);
    localparam logic [X_BW-1:0]    X_ACT     = X_BW'(H_ACT);
    localparam logic [Y_BW-1:0]    Y_LAST    = Y_BW'(V_ACT - 1);
    localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(H_ACT * V_ACT - 1);

    logic [X_BW-1:0]    r_x,    w_x_nxt;
    logic [Y_BW-1:0]    r_y,    w_y_nxt;
    logic [ADDR_BW-1:0] r_addr, w_addr_nxt;
    logic               r_rd_en;
    logic               w_eol;

    assign w_eol = (r_x == X_LAST);

    always_comb begin
        // NOTE: every next-value gets a default first, so no path leaves one unassigned (no latch).
        w_x_nxt    = r_x;
        w_y_nxt    = r_y;
        w_addr_nxt = r_addr;
        if (i_clear) begin
            w_x_nxt    = '0;
            w_y_nxt    = '0;
            w_addr_nxt = '0;
        end else begin
            if (i_en) begin
                if (w_eol) begin
                    w_x_nxt = '0;
                    if (r_y != Y_LAST) w_y_nxt = r_y + 1'b1;
                end else begin
                    w_x_nxt = r_x + 1'b1;
                end
            end
            // Address advances after each read; wraps so it never leaves the store range.
            if (r_rd_en) w_addr_nxt = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
        end
    end

    // NOTE: all state updates use non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
        end else begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_addr  <= w_addr_nxt;
            r_rd_en <= i_act_nxt && (w_x_nxt < X_ACT);
        end
    end

    assign o_eol   = w_eol;
    assign o_y     = r_y;
    assign o_rd_en = r_rd_en;
    assign o_addr  = r_addr;

endmodule

// File: rtl/corr_frame_seq.sv
// Frame sequencer: streams frame1 (reference) and, LEAD_LINES later, frame0
// (current), with registered read enables, valids and frame pulses.
module corr_frame_seq
    import RgbdVoConfigPk::*;
#(
    parameter int H_ACT      = CFG_H_ACT,
    parameter int H_BLANK    = CFG_H_BLANK,
    parameter int V_ACT      = CFG_V_ACT,
    parameter int LEAD_LINES = CFG_LEAD_LINES,
    parameter int ADDR_BW    = CFG_ADDR_BW
) (
    input  logic            clk,
    input  logic            rst_n,
    corr_frame_seq_if.slave bus
);
    localparam int Y_BW = cnt_bw(V_ACT);

    localparam logic [Y_BW-1:0]    Y_LAST    = Y_BW'(V_ACT - 1);
    localparam logic [Y_BW-1:0]    Y_LEAD    = Y_BW'(LEAD_LINES - 1);
    localparam logic [ADDR_BW-1:0] ADDR_LAST = ADDR_BW'(H_ACT * V_ACT - 1);

    seq_state_e         r_state, w_state_nxt;
    logic               w_start_acc;
    logic               w_en1, w_en0, w_act1_nxt, w_act0_nxt;
    logic               w_eol1, w_eol0;
    logic [Y_BW-1:0]    w_y1, w_y0;
    logic               w_rd_en1, w_rd_en0;
    logic [ADDR_BW-1:0] w_addr1, w_addr0;
    logic               r_busy, r_valid1, r_valid0, r_frame_start, r_last0, r_frame_end;

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        if (bus.i_abort) begin
            w_state_nxt = SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE:  if (bus.i_start) begin
                               w_state_nxt = SEQ_LEAD;
                               w_start_acc = 1'b1;
                           end
                SEQ_LEAD:  if (w_eol1 && (w_y1 == Y_LEAD)) w_state_nxt = SEQ_BOTH;
                SEQ_BOTH:  if (w_eol1 && (w_y1 == Y_LAST)) w_state_nxt = SEQ_DRAIN;
                SEQ_DRAIN: if (w_eol0 && (w_y0 == Y_LAST)) w_state_nxt = SEQ_IDLE;
                default:   w_state_nxt = SEQ_IDLE;
            endcase
        end
        w_en1      = (r_state == SEQ_LEAD)     || (r_state == SEQ_BOTH);
        w_en0      = (r_state == SEQ_BOTH)     || (r_state == SEQ_DRAIN);
        w_act1_nxt = (w_state_nxt == SEQ_LEAD) || (w_state_nxt == SEQ_BOTH);
        w_act0_nxt = (w_state_nxt == SEQ_BOTH) || (w_state_nxt == SEQ_DRAIN);
    end

    raster_cnt #(.H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT), .ADDR_BW(ADDR_BW), .Y_BW(Y_BW))
    u_cnt1 (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_en(w_en1), .i_act_nxt(w_act1_nxt),
        .o_eol(w_eol1), .o_y(w_y1), .o_rd_en(w_rd_en1), .o_addr(w_addr1)
    );

    // Frame0 counters are cleared at start too and simply hold at 0 through LEAD.
    raster_cnt #(.H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT), .ADDR_BW(ADDR_BW), .Y_BW(Y_BW))
    u_cnt0 (
        .clk(clk), .rst_n(rst_n), .i_clear(w_start_acc), .i_en(w_en0), .i_act_nxt(w_act0_nxt),
        .o_eol(w_eol0), .o_y(w_y0), .o_rd_en(w_rd_en0), .o_addr(w_addr0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SEQ_IDLE;
            r_busy        <= 1'b0;
            r_valid1      <= 1'b0;
            r_valid0      <= 1'b0;
            r_frame_start <= 1'b0;
            r_last0       <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt != SEQ_IDLE);
            r_valid1      <= w_rd_en1;
            r_valid0      <= w_rd_en0;
            r_frame_start <= w_start_acc;
            // Abort flushes the end-of-frame pipeline so no frame_end escapes.
            r_last0       <= !bus.i_abort && w_rd_en0 && (w_addr0 == ADDR_LAST);
            r_frame_end   <= !bus.i_abort && r_last0;
        end
    end

    assign bus.o_busy        = r_busy;
    assign bus.o_rd_en1      = w_rd_en1;
    assign bus.o_rd_addr1    = w_addr1;
    assign bus.o_rd_en0      = w_rd_en0;
    assign bus.o_rd_addr0    = w_addr0;
    assign bus.o_valid1      = r_valid1;
    assign bus.o_valid0      = r_valid0;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_frame_end   = r_frame_end;

endmodule

// File: tb/tb_corr_frame_seq.sv
// Scoreboard bench for corr_frame_seq with 8+4 x 6 raster and a 2-line lead.
module tb_corr_frame_seq;

    localparam int H_ACT   = 8;
    localparam int H_TOTAL = 12;
    localparam int V_ACT   = 6;
    localparam int LEAD    = 2;
    localparam int C_FEND  = 93;
    localparam int NO_CUT  = 1 << 30;

    typedef struct {
        int cyc;
        int addr;
    } rd_ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   n_v0 = 0;
    int   n_v1 = 0;

    rd_ev_t q_rd1[$];
    rd_ev_t q_rd0[$];
    int     q_v1[$];
    int     q_v0[$];
    int     q_fs[$];
    int     q_fe[$];

    corr_frame_seq_if #(.ADDR_BW(19)) bus ();

    corr_frame_seq #(
        .H_ACT(8), .H_BLANK(4), .V_ACT(6), .LEAD_LINES(2), .ADDR_BW(19)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  int'(bus.o_busy), 0);
        check({tag, "_rden1"}, int'(bus.o_rd_en1), 0);
        check({tag, "_rden0"}, int'(bus.o_rd_en0), 0);
        check({tag, "_addr1"}, int'(bus.o_rd_addr1), 0);
        check({tag, "_addr0"}, int'(bus.o_rd_addr0), 0);
        check({tag, "_vld1"},  int'(bus.o_valid1), 0);
        check({tag, "_vld0"},  int'(bus.o_valid0), 0);
        check({tag, "_fs"},    int'(bus.o_frame_start), 0);
        check({tag, "_fe"},    int'(bus.o_frame_end), 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_left_rd1"}, q_rd1.size(), 0);
        check({tag, "_left_rd0"}, q_rd0.size(), 0);
        check({tag, "_left_v1"},  q_v1.size(),  0);
        check({tag, "_left_v0"},  q_v0.size(),  0);
        check({tag, "_left_fs"},  q_fs.size(),  0);
        check({tag, "_left_fe"},  q_fe.size(),  0);
    endtask

    // Expected events of one run starting at cycle b; reads after last_rd and
    // valids after last_vld are dropped (abort/reset truncation).
    task automatic push_run(input int b, input int last_rd, input int last_vld, input bit with_end);
        int c1;
        int c0;
        q_fs.push_back(b);
        for (int n = 0; n < V_ACT; n++) begin
            for (int x = 0; x < H_ACT; x++) begin
                c1 = b + n * H_TOTAL + x;
                c0 = b + (LEAD + n) * H_TOTAL + x;
                if (c1 <= last_rd) q_rd1.push_back('{c1, n * H_ACT + x});
                if (c1 + 1 <= last_vld) q_v1.push_back(c1 + 1);
                if (c0 <= last_rd) q_rd0.push_back('{c0, n * H_ACT + x});
                if (c0 + 1 <= last_vld) q_v0.push_back(c0 + 1);
            end
        end
        if (with_end) q_fe.push_back(b + C_FEND);
    endtask

    // Monitor: every presented output event pops and compares its expectation.
    always @(negedge clk) begin
        rd_ev_t e;
        if (bus.o_rd_en1) begin
            if (q_rd1.size() == 0) check("rd1_unexpected", cyc, -1);
            else begin
                e = q_rd1.pop_front();
                check("rd1_cycle", cyc, e.cyc);
                check("rd1_addr", int'(bus.o_rd_addr1), e.addr);
            end
        end
        if (bus.o_rd_en0) begin
            if (q_rd0.size() == 0) check("rd0_unexpected", cyc, -1);
            else begin
                e = q_rd0.pop_front();
                check("rd0_cycle", cyc, e.cyc);
                check("rd0_addr", int'(bus.o_rd_addr0), e.addr);
            end
        end
        if (bus.o_valid1) begin
            n_v1++;
            if (q_v1.size() == 0) check("vld1_unexpected", cyc, -1);
            else check("vld1_cycle", cyc, q_v1.pop_front());
        end
        if (bus.o_valid0) begin
            n_v0++;
            if (q_v0.size() == 0) check("vld0_unexpected", cyc, -1);
            else check("vld0_cycle", cyc, q_v0.pop_front());
        end
        if (bus.o_frame_start) begin
            if (q_fs.size() == 0) check("fs_unexpected", cyc, -1);
            else check("fs_cycle", cyc, q_fs.pop_front());
        end
        if (bus.o_frame_end) begin
            if (q_fe.size() == 0) check("fe_unexpected", cyc, -1);
            else check("fe_cycle", cyc, q_fe.pop_front());
        end
    end

    initial begin
        int b;
        int b2;
        int v0_snap;
        int v1_snap;

        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        wait_cyc(2);
        check_idle("reset");
        rst_n = 1'b1;
        wait_cyc(6);
        check_idle("idle");

        // Nominal run.
        wait_cyc(10);
        b = cyc + 1;
        push_run(b, NO_CUT, NO_CUT, 1'b1);
        bus.i_start = 1'b1;
        wait_cyc(b);
        bus.i_start = 1'b0;
        check("nom_busy_c0", int'(bus.o_busy), 1);
        check("nom_fs_c0", int'(bus.o_frame_start), 1);
        wait_cyc(b + 95);
        check("nom_busy_c95", int'(bus.o_busy), 1);
        wait_cyc(b + 96);
        check("nom_busy_c96", int'(bus.o_busy), 0);
        wait_cyc(b + 100);
        check_drained("nom");

        // Start pulsed mid-run must be ignored.
        b = cyc + 1;
        push_run(b, NO_CUT, NO_CUT, 1'b1);
        bus.i_start = 1'b1;
        wait_cyc(b);
        bus.i_start = 1'b0;
        wait_cyc(b + 40);
        bus.i_start = 1'b1;
        wait_cyc(b + 41);
        bus.i_start = 1'b0;
        wait_cyc(b + 100);
        check_drained("busy_start");

        // Abort at cycle 30, restart at cycle 35.
        b = cyc + 1;
        push_run(b, b + 30, b + 31, 1'b0);
        bus.i_start = 1'b1;
        wait_cyc(b);
        bus.i_start = 1'b0;
        wait_cyc(b + 30);
        bus.i_abort = 1'b1;
        wait_cyc(b + 31);
        bus.i_abort = 1'b0;
        check("abort_busy_c31", int'(bus.o_busy), 0);
        check("abort_rden1_c31", int'(bus.o_rd_en1), 0);
        check("abort_rden0_c31", int'(bus.o_rd_en0), 0);
        check("abort_vld1_c31", int'(bus.o_valid1), 1);
        wait_cyc(b + 32);
        check("abort_vld1_c32", int'(bus.o_valid1), 0);
        check("abort_vld0_c32", int'(bus.o_valid0), 0);
        wait_cyc(b + 33);
        check_drained("abort");
        wait_cyc(b + 34);
        b2 = b + 35;
        push_run(b2, NO_CUT, NO_CUT, 1'b1);
        bus.i_start = 1'b1;
        wait_cyc(b2);
        bus.i_start = 1'b0;
        wait_cyc(b2 + 100);
        check_drained("restart");

        // Asynchronous reset at cycle 50.
        b = cyc + 1;
        push_run(b, b + 49, b + 49, 1'b0);
        bus.i_start = 1'b1;
        wait_cyc(b);
        bus.i_start = 1'b0;
        wait_cyc(b + 50);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        wait_cyc(b + 52);
        rst_n = 1'b1;
        wait_cyc(b + 62);
        check_idle("post_rst");
        check_drained("rst");

        // Back-to-back runs with i_start held high.
        v0_snap = n_v0;
        v1_snap = n_v1;
        b  = cyc + 1;
        b2 = b + 97;
        push_run(b, NO_CUT, NO_CUT, 1'b1);
        push_run(b2, NO_CUT, NO_CUT, 1'b1);
        bus.i_start = 1'b1;
        wait_cyc(b + 96);
        check("b2b_busy_c96", int'(bus.o_busy), 0);
        wait_cyc(b2);
        check("b2b_busy_run2_c0", int'(bus.o_busy), 1);
        wait_cyc(b2 + 5);
        bus.i_start = 1'b0;
        wait_cyc(b2 + 100);
        check_drained("b2b");
        check("b2b_vld0_count", n_v0 - v0_snap, 96);
        check("b2b_vld1_count", n_v1 - v1_snap, 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
